// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter width; a 1-bit adder still needs a 1-bit counter register.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/ha_cell.sv
// Gate-level half adder; two of these form the serial adder's full-adder bit slice.
module ha_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add the in_sub port (A-B via ~B plus carry-in 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             cin;
  logic [WIDTH-1:0] opb_load;
  logic             ha0_sum;
  logic             ha0_carry;
  logic             bit_sum;
  logic             ha1_carry;
  logic             carry_next;
  logic [WIDTH-1:0] sum_shift;

`ifdef SERIAL_ADDER_SUB_EN
  assign cin = in_sub;
`else
  assign cin = 1'b0;
`endif

  assign opb_load = in_b ^ {WIDTH{cin}};

  ha_cell u_ha0 (
    .a     (opa_q[0]),
    .b     (opb_q[0]),
    .sum   (ha0_sum),
    .carry (ha0_carry)
  );

  ha_cell u_ha1 (
    .a     (ha0_sum),
    .b     (carry_q),
    .sum   (bit_sum),
    .carry (ha1_carry)
  );

  assign carry_next = ha0_carry | ha1_carry;
  // New bit enters at the MSB; written as shifts so WIDTH=1 stays legal.
  assign sum_shift  = (sum_q >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            opa_q      <= in_a;
            opb_q      <= opb_load;
            carry_q    <= cin;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          sum_q   <= sum_shift;
          carry_q <= carry_next;
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          count_q <= count_q + CNT_W'(1);
          if (count_q == LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 plus a WIDTH=1 instance), scoreboard based.
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;

  logic v1, r1, a1, b1, ir1, ov1, s1, c1;

  int checks = 0;
  int errors = 0;
  logic [W:0] sb_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1),
    .in_ready  (ir1),
    .in_a      (a1),
    .in_b      (b1),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub    (1'b0),
`endif
    .out_valid (ov1),
    .out_ready (r1),
    .out_sum   (s1),
    .out_carry (c1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                           output bit ok);
    int n;
    logic [W-1:0] bb;
    ok = 1'b0;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      return;
    end
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_valid = 1'b1;
    bb = sub ? ~b : b;
    @(posedge clk);
    sb_q.push_back({1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub});
    #1;
    in_valid = 1'b0;
    check_eq("busy_in_ready", 32'(in_ready), 32'd0);
    ok = 1'b1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int hold);
    int n;
    bit ok;
    logic [W:0] exp;
    accept_op(a, b, sub, ok);
    if (!ok) return;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("latency", 32'(n), 32'(W));
    if (!out_valid) return;
    check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() == 0) return;
    exp = sb_q.pop_front();
    check_eq("sum", 32'(out_sum), 32'(exp[W-1:0]));
    check_eq("carry", 32'(out_carry), 32'(exp[W]));
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 2 == 0);
      in_a     = ~a;
      @(posedge clk);
      #1;
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_sum", 32'(out_sum), 32'(exp[W-1:0]));
      check_eq("hold_carry", 32'(out_carry), 32'(exp[W]));
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("done_valid_low", 32'(out_valid), 32'd0);
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_out_sum"}, 32'(out_sum), 32'd0);
    check_eq({tag, "_out_carry"}, 32'(out_carry), 32'd0);
  endtask

  initial begin
    bit ok;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    v1 = 1'b0; r1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check_eq("reset_w1_in_ready", 32'(ir1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'hA5, 8'h5A, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h00, 8'h00, 1'b0, 0);
    run_op(8'h3C, 8'hC7, 1'b0, 5);

    // Reset after the third shift edge, then a clean operation.
    accept_op(8'h77, 8'h99, 1'b0, ok);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h20, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 0);
    run_op(8'h07, 8'h05, 1'b1, 2);
`endif

    for (int k = 0; k < 6; k++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(1, 0));
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rs, k % 3);
    end

    // WIDTH=1: 1+1 gives sum 0, carry 1 one clock after accept.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    check_eq("w1_busy", 32'(ov1), 32'd0);
    @(posedge clk);
    #1;
    check_eq("w1_valid", 32'(ov1), 32'd1);
    check_eq("w1_sum", 32'(s1), 32'd0);
    check_eq("w1_carry", 32'(c1), 32'd1);
    r1 = 1'b1;
    @(posedge clk);
    #1;
    r1 = 1'b0;
    check_eq("w1_idle", 32'(ir1), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
